rv32_barrel_csr_bank: RTL

Parametrised successor to the per-hart CSR file array used by the barrel core. It holds NUM_HARTS machine-mode CSR sets in one banked structure, indexed by the issuing hart. It adds per-hart interrupt synchronisation, sticky MVU pending bits, trap-entry and mret state updates, and a per-hart interrupt request output. It sits between the barrel decode/execute stage and the trap logic; one hart accesses it per cycle.

---
 rtl/rv32_barrel_csr_bank.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rv32_barrel_csr_bank.sv
// Banked machine-mode CSR file for the barrel core: one CSR set per hart,
// selected by the issuing hart, plus per-hart interrupt synchronisers,
// sticky MVU pending bits, trap/mret handling and a shared cycle counter.
module rv32_barrel_csr_bank #(
    parameter int          NUM_HARTS   = 8,
    parameter int          HART_W      = $clog2(NUM_HARTS),
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [HART_W-1:0]    hart_id_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [1:0]           csr_op_i,
    input  logic [31:0]          csr_wdata_i,
    output logic [31:0]          csr_rdata_o,
    output logic                 csr_illegal_o,
    input  logic                 trap_i,
    input  logic [31:0]          trap_cause_i,
    input  logic [31:0]          trap_pc_i,
    input  logic                 mret_i,
    input  logic [NUM_HARTS-1:0] irq_i,
    input  logic [NUM_HARTS-1:0] time_irq_i,
    input  logic [NUM_HARTS-1:0] ipi_i,
    input  logic [NUM_HARTS-1:0] mvu_irq_i,
    input  logic                 enable_cycle_count_i,
    output logic [NUM_HARTS-1:0] irq_req_o,
    output logic [31:0]          csr_epc_o,
    output logic [31:0]          csr_mtvec_o,
    output logic [1:0]           csr_mvu_mul_mode_o
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MULMODE  = 12'h7C0;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0001_0888;

    // Per-hart state, stored already masked so reads need no extra gating
    logic [NUM_HARTS-1:0][31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [NUM_HARTS-1:0][1:0]  mul_mode_q;
    logic [NUM_HARTS-1:0]       mvu_pend_q;
    logic [NUM_HARTS-1:0][SYNC_STAGES-1:0] ext_sync_q, tim_sync_q, ipi_sync_q;
    logic [63:0] cycle_q;

    logic [NUM_HARTS-1:0][31:0] mip_v;
    logic [NUM_HARTS-1:0]       hart_sel, mip_clr;
    logic [31:0] wr_val;
    logic        known, ro, wr_en, evt;

    // Assemble each hart's mip view from synchronised lines and sticky MVU bit
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            mip_v[h] = {15'b0, mvu_pend_q[h], 4'b0, ext_sync_q[h][SYNC_STAGES-1], 3'b0,
                        tim_sync_q[h][SYNC_STAGES-1], 3'b0, ipi_sync_q[h][SYNC_STAGES-1], 3'b0};
            irq_req_o[h] = mstatus_q[h][3] & (|(mip_v[h] & mie_q[h]));
        end
    end

    // Address decode, pre-op read value and legality check
    always_comb begin
        csr_rdata_o = '0;
        known       = 1'b1;
        ro          = 1'b0;
        case (csr_addr_i)
            A_MSTATUS:  csr_rdata_o = mstatus_q[hart_id_i];
            A_MIE:      csr_rdata_o = mie_q[hart_id_i];
            A_MIP:      csr_rdata_o = mip_v[hart_id_i];
            A_MTVEC:    csr_rdata_o = mtvec_q[hart_id_i];
            A_MSCRATCH: csr_rdata_o = mscratch_q[hart_id_i];
            A_MEPC:     csr_rdata_o = mepc_q[hart_id_i];
            A_MCAUSE:   csr_rdata_o = mcause_q[hart_id_i];
            A_MULMODE:  csr_rdata_o = {30'b0, mul_mode_q[hart_id_i]};
            A_MHARTID:  begin csr_rdata_o = 32'(hart_id_i); ro = 1'b1; end
            A_MCYCLE:   begin csr_rdata_o = cycle_q[31:0];  ro = 1'b1; end
            A_MCYCLEH:  begin csr_rdata_o = cycle_q[63:32]; ro = 1'b1; end
            default:    known = 1'b0;
        endcase
        csr_illegal_o = (csr_op_i != 2'd0) && (!known || ro);
    end

    // Read-modify-write value and per-hart strobes for the current op
    always_comb begin
        case (csr_op_i)
            2'd1:    wr_val = csr_wdata_i;
            2'd2:    wr_val = csr_rdata_o | csr_wdata_i;
            2'd3:    wr_val = csr_rdata_o & ~csr_wdata_i;
            default: wr_val = csr_rdata_o;
        endcase
        wr_en    = (csr_op_i != 2'd0) && !csr_illegal_o;
        evt      = trap_i | mret_i;
        hart_sel = '0;
        hart_sel[hart_id_i] = 1'b1;
        mip_clr  = hart_sel & {NUM_HARTS{wr_en && (csr_addr_i == A_MIP) &&
                                         (csr_op_i == 2'd3) && csr_wdata_i[16]}};
    end

    // Per-hart CSR updates: trap beats mret, both beat ops to mstatus/mepc/mcause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_q  <= '0;
            mie_q      <= '0;
            mtvec_q    <= {NUM_HARTS{RESET_MTVEC & ~32'h3}};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mul_mode_q <= '0;
            mvu_pend_q <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (hart_sel[h]) begin
                    if (trap_i) begin
                        mstatus_q[h] <= {24'b0, mstatus_q[h][3], 7'b0};
                        mepc_q[h]    <= trap_pc_i & 32'hFFFF_FFFE;
                        mcause_q[h]  <= trap_cause_i;
                    end else if (mret_i) begin
                        mstatus_q[h] <= {24'b0, 1'b1, 3'b0, mstatus_q[h][7], 3'b0};
                    end
                    if (wr_en && !evt) begin
                        case (csr_addr_i)
                            A_MSTATUS: mstatus_q[h] <= wr_val & MSTATUS_MASK;
                            A_MEPC:    mepc_q[h]    <= wr_val & 32'hFFFF_FFFE;
                            A_MCAUSE:  mcause_q[h]  <= wr_val;
                            default:   ;
                        endcase
                    end
                    if (wr_en) begin
                        case (csr_addr_i)
                            A_MIE:      mie_q[h]      <= wr_val & MIE_MASK;
                            A_MTVEC:    mtvec_q[h]    <= wr_val & ~32'h3;
                            A_MSCRATCH: mscratch_q[h] <= wr_val;
                            A_MULMODE:  mul_mode_q[h] <= wr_val[1:0];
                            default:    ;
                        endcase
                    end
                end
                // A new MVU pulse wins over a simultaneous clear
                mvu_pend_q[h] <= mvu_irq_i[h] | (mvu_pend_q[h] & ~mip_clr[h]);
            end
        end
    end

    // Synchronise asynchronous interrupt lines for every hart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync_q <= '0;
            tim_sync_q <= '0;
            ipi_sync_q <= '0;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                ext_sync_q[h] <= {ext_sync_q[h][SYNC_STAGES-2:0], irq_i[h]};
                tim_sync_q[h] <= {tim_sync_q[h][SYNC_STAGES-2:0], time_irq_i[h]};
                ipi_sync_q[h] <= {ipi_sync_q[h][SYNC_STAGES-2:0], ipi_i[h]};
            end
        end
    end

    // Shared 64-bit cycle counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cycle_q <= '0;
        else if (enable_cycle_count_i) cycle_q <= cycle_q + 64'd1;
    end

    assign csr_epc_o          = mepc_q[hart_id_i];
    assign csr_mtvec_o        = mtvec_q[hart_id_i];
    assign csr_mvu_mul_mode_o = mul_mode_q[hart_id_i];
endmodule
